hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage core. It drives the `block_lN` / `clear_lN` controls of the four pipeline registers L1 (IF/ID), L2 (ID/EX), L3 (EX/MEM) and L4 (MEM/WB), and the PC hold. It resolves three hazard types:
- load-use hazards between ID and EX;
- control redirects resolved in EX;
- multi-cycle data-memory accesses in MEM.

Waits are supervised by a timeout and counted for performance.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/sat_counter.sv | 29 ++
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, default wait budget, the hard-wired zero register index and
// a small operand-match helper used by load-use detection.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hazard_state_e;

  localparam int unsigned MAX_WAIT_DEF = 255;
  localparam logic [4:0]  REG_X0       = 5'd0;

  // True when the ID instruction actually reads src and src names dst.
  function automatic logic src_match(input logic       use_src,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
    return use_src & (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones
// instead of wrapping, so a long run never reports a misleadingly small value.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic [W-1:0] count_r;

  // Increment on request unless already saturated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != ALL_ONES)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage core.
// Resolves data-memory waits (highest priority), EX-stage redirects and
// ID/EX load-use hazards, and drives the hold/bubble controls of the four
// pipeline registers plus the PC hold. Controls are combinational so the
// pipe reacts in the same cycle; FSM, wait counter, error flag and
// performance counters are registered.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       rs1_l1,
  input  logic [4:0]       rs2_l1,
  input  logic             use_rs1_l1,
  input  logic             use_rs2_l1,
  input  logic [4:0]       rd_l2,
  input  logic             load_l2,
  input  logic             jump_l2,
  input  logic             load_l3,
  input  logic             store_l3,
  input  logic             dmem_ready,
  output logic             pc_hold,
  output logic             block_l1,
  output logic             block_l2,
  output logic             block_l3,
  output logic             block_l4,
  output logic             clear_l1,
  output logic             clear_l2,
  output logic             clear_l3,
  output logic             clear_l4,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned      WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP  = WAIT_W'(MAX_WAIT);

  hazard_state_e     state_r;
  hazard_state_e     state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              mem_err_r;

  logic mem_busy_s;
  logic lu_hit_s;
  logic timeout_s;
  logic flush_s;

  assign mem_busy_s = (load_l3 | store_l3) & ~dmem_ready;

  // x0 never carries a real dependency, so a load targeting it never stalls.
  assign lu_hit_s = load_l2 & (rd_l2 != REG_X0) &
                    (src_match(use_rs1_l1, rs1_l1, rd_l2) |
                     src_match(use_rs2_l1, rs2_l1, rd_l2));

  // This busy cycle is the last one tolerated before declaring a timeout.
  assign timeout_s = mem_busy_s & (wait_cnt_r == WAIT_LAST);

  // Next FSM state: a busy memory enters/holds the wait, ERR is sticky.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN, MEM_WAIT: begin
        if (timeout_s) begin
          state_nxt_s = ERR;
        end else if (mem_busy_s) begin
          state_nxt_s = MEM_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      ERR:     state_nxt_s = ERR;
      default: state_nxt_s = RUN;
    endcase
  end

  // Wait counter: consecutive busy cycles, restarting after any idle cycle.
  always_comb begin
    wait_cnt_nxt_s = wait_cnt_r;
    if (!mem_busy_s) begin
      wait_cnt_nxt_s = {WAIT_W{1'b0}};
    end else if (wait_cnt_r != WAIT_TOP) begin
      wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_nxt_s = wait_cnt_r;
    end
  end

  // FSM, wait counter and sticky error flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      mem_err_r  <= mem_err_r | (state_nxt_s == ERR);
    end
  end

  // Prioritised pipeline controls: memory stall/error, redirect, load-use.
  always_comb begin
    pc_hold  = 1'b0;
    block_l1 = 1'b0;
    block_l2 = 1'b0;
    block_l3 = 1'b0;
    block_l4 = 1'b0;
    clear_l1 = 1'b0;
    clear_l2 = 1'b0;
    clear_l3 = 1'b0;
    clear_l4 = 1'b0;
    flush_s  = 1'b0;
    if (!rstn) begin
      pc_hold = 1'b0;
    end else if ((state_r == ERR) || mem_busy_s) begin
      // Freeze IF..MEM; WB receives a bubble so the stalled access never retires twice.
      pc_hold  = 1'b1;
      block_l1 = 1'b1;
      block_l2 = 1'b1;
      block_l3 = 1'b1;
      clear_l4 = 1'b1;
    end else if (jump_l2) begin
      // Squash the two younger instructions; any load-use stall is moot.
      clear_l1 = 1'b1;
      clear_l2 = 1'b1;
      flush_s  = 1'b1;
    end else if (lu_hit_s) begin
      pc_hold  = 1'b1;
      block_l1 = 1'b1;
      clear_l2 = 1'b1;
    end else begin
      pc_hold = 1'b0;
    end
  end

  assign mem_err = mem_err_r;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (pc_hold),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (flush_s),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MAX_WAIT=4, 4-bit counters so that
// saturation is reachable). Each driven cycle pushes its hand-computed
// expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] rs1_l1, rs2_l1, rd_l2;
  logic       use_rs1_l1, use_rs2_l1, load_l2, jump_l2;
  logic       load_l3, store_l3, dmem_ready;
  logic       pc_hold, block_l1, block_l2, block_l3, block_l4;
  logic       clear_l1, clear_l2, clear_l3, clear_l4, mem_err;
  logic [3:0] stall_cnt, flush_cnt;

  // {pc_hold, block_l1..l4, clear_l1..l4}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_LU   = 9'b110000100;
  localparam logic [8:0] C_FL   = 9'b000001100;
  localparam logic [8:0] C_ST   = 9'b111100001;

  typedef struct {
    string      tag;
    logic [8:0] ctrl;
    logic       err;
    logic [3:0] stall;
    logic [3:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rs1_l1     (rs1_l1),
    .rs2_l1     (rs2_l1),
    .use_rs1_l1 (use_rs1_l1),
    .use_rs2_l1 (use_rs2_l1),
    .rd_l2      (rd_l2),
    .load_l2    (load_l2),
    .jump_l2    (jump_l2),
    .load_l3    (load_l3),
    .store_l3   (store_l3),
    .dmem_ready (dmem_ready),
    .pc_hold    (pc_hold),
    .block_l1   (block_l1),
    .block_l2   (block_l2),
    .block_l3   (block_l3),
    .block_l4   (block_l4),
    .clear_l1   (clear_l1),
    .clear_l2   (clear_l2),
    .clear_l3   (clear_l3),
    .clear_l4   (clear_l4),
    .mem_err    (mem_err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  // Monitor: compare one expectation per cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = exp_q.pop_front();
      act = {pc_hold, block_l1, block_l2, block_l3, block_l4,
             clear_l1, clear_l2, clear_l3, clear_l4};
      tests_run++;
      if ({act, mem_err, stall_cnt, flush_cnt} !== {e.ctrl, e.err, e.stall, e.flush}) begin
        tests_failed++;
        $display("FAIL %s: got ctrl=%b err=%b stall=%0d flush=%0d, want ctrl=%b err=%b stall=%0d flush=%0d",
                 e.tag, act, mem_err, stall_cnt, flush_cnt, e.ctrl, e.err, e.stall, e.flush);
      end
    end
  end

  // Drive one cycle of inputs and queue its expected response.
  task automatic step(input string tag, input logic rn,
                      input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic l2, input logic j,
                      input logic l3, input logic s3, input logic rdy,
                      input logic [8:0] ec, input logic ee,
                      input logic [3:0] es, input logic [3:0] ef);
    exp_t e;
    rstn       = rn;
    rs1_l1     = r1;
    use_rs1_l1 = u1;
    rs2_l1     = r2;
    use_rs2_l1 = u2;
    rd_l2      = rd;
    load_l2    = l2;
    jump_l2    = j;
    load_l3    = l3;
    store_l3   = s3;
    dmem_ready = rdy;
    e.tag   = tag;
    e.ctrl  = ec;
    e.err   = ee;
    e.stall = es;
    e.flush = ef;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    rs1_l1 = 5'd0; rs2_l1 = 5'd0; rd_l2 = 5'd0;
    use_rs1_l1 = 1'b0; use_rs2_l1 = 1'b0; load_l2 = 1'b0; jump_l2 = 1'b0;
    load_l3 = 1'b0; store_l3 = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    //     tag            rn    rs1  u1    rs2  u2    rd   ld2   jmp   ld3   st3   rdy   ctrl   err   stall  flush
    step("reset_a",      1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_NONE, 1'b0, 4'd0,  4'd0);
    step("reset_b",      1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 4'd0,  4'd0);
    step("idle",         1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 4'd0,  4'd0);
    step("lu_rs2",       1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,   1'b0, 4'd0,  4'd0);
    step("lu_bubble",    1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 4'd1,  4'd0);
    step("x0_exempt",    1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 4'd1,  4'd0);
    step("use_flag_off", 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 4'd1,  4'd0);
    step("lu_rs1",       1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,   1'b0, 4'd1,  4'd0);
    step("jump_beats_lu",1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_FL,   1'b0, 4'd2,  4'd0);
    step("after_jump",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 4'd2,  4'd1);
    step("mwait_1",      1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd2,  4'd1);
    step("mwait_2",      1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd3,  4'd1);
    step("mwait_3",      1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd4,  4'd1);
    step("mwait_ready",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_NONE, 1'b0, 4'd5,  4'd1);
    step("mwait_after",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 4'd5,  4'd1);
    step("mem_over_jmp", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd5,  4'd1);
    step("jmp_on_ready", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, C_FL,   1'b0, 4'd6,  4'd1);
    step("jmp_counted",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 4'd6,  4'd2);
    step("b2b_a1",       1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd6,  4'd2);
    step("b2b_a2",       1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd7,  4'd2);
    step("b2b_a3",       1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd8,  4'd2);
    step("b2b_gap",      1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_NONE, 1'b0, 4'd9,  4'd2);
    step("b2b_st1",      1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_ST,   1'b0, 4'd9,  4'd2);
    step("b2b_st2",      1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_ST,   1'b0, 4'd10, 4'd2);
    step("b2b_st3",      1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_ST,   1'b0, 4'd11, 4'd2);
    step("b2b_ready",    1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE, 1'b0, 4'd12, 4'd2);
    step("tmo_1",        1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd12, 4'd2);
    step("tmo_2",        1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd13, 4'd2);
    step("tmo_3",        1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd14, 4'd2);
    step("tmo_4",        1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ST,   1'b0, 4'd15, 4'd2);
    step("err_idle_sat", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_ST,   1'b1, 4'd15, 4'd2);
    step("err_sticky",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, C_ST,   1'b1, 4'd15, 4'd2);
    step("err_reset",    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_NONE, 1'b0, 4'd0,  4'd0);
    step("post_reset",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 4'd0,  4'd0);
    step("post_lu",      1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,   1'b0, 4'd0,  4'd0);
    step("post_jump",    1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_FL,   1'b0, 4'd1,  4'd0);
    step("post_final",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 4'd1,  4'd1);
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
